// File: rtl/mem_subword_unit_if.sv
// Core request/response and word-memory signals of the sub-word load/store unit.
// slave = the unit itself, master = the core plus memory that surround it.
interface mem_subword_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [29:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_subword_unit.sv
// Byte/half/word load-store unit over a 1-cycle word memory; sub-word stores are read-modify-write.
// Response after 1 (error), 2 (word store), 3 (load) or 4 (sub-word store) cycles; req_ready only in IDLE.
module mem_subword_unit (
  input  logic                clk,
  input  logic                rst_n,
  mem_subword_unit_if.slave   bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_WRITE,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_merged;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic        w_accept;
  logic        w_legal;
  logic [4:0]  w_bsh;
  logic [4:0]  w_hsh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  assign w_accept = bus.req_valid && (r_state == S_IDLE);

  always_comb begin
    w_legal = 1'b0;
    case (bus.req_size)
      2'b00:   w_legal = 1'b1;
      2'b01:   w_legal = ~bus.req_addr[0];
      2'b10:   w_legal = (bus.req_addr[1:0] == 2'b00);
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_legal)                                 w_next = S_RESP;
          else if (bus.req_we && bus.req_size == 2'b10) w_next = S_WRITE;
          else                                          w_next = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: w_next = S_RD_WAIT;
      S_RD_WAIT:  w_next = r_we ? S_WRITE : S_RESP;
      S_WRITE:    w_next = S_RESP;
      S_RESP:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Lane selection from the latched address; byte shift = 8*addr[1:0], half shift = 16*addr[1].
  assign w_bsh  = {r_addr[1:0], 3'b000};
  assign w_hsh  = {r_addr[1], 4'b0000};
  assign w_byte = bus.mem_rdata[w_bsh +: 8];
  assign w_half = bus.mem_rdata[w_hsh +: 16];

  always_comb begin
    w_load = bus.mem_rdata;
    case (r_size)
      2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load = bus.mem_rdata;
    endcase
  end

  always_comb begin
    w_merge = bus.mem_rdata;
    if (r_size == 2'b00) w_merge[w_bsh +: 8]  = r_wdata[7:0];
    else                 w_merge[w_hsh +: 16] = r_wdata[15:0];
  end

  // Response registers only change on the edge entering RESP, so they hold between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_signed    <= 1'b0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_merged    <= 32'h0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we     <= bus.req_we;
        r_size   <= bus.req_size;
        r_signed <= bus.req_signed;
        r_addr   <= bus.req_addr;
        r_wdata  <= bus.req_wdata;
        if (!w_legal) begin
          r_rsp_rdata <= 32'h0;
          r_rsp_err   <= 1'b1;
        end
      end
      if (r_state == S_RD_WAIT) begin
        if (r_we) begin
          r_merged <= w_merge;
        end else begin
          r_rsp_rdata <= w_load;
          r_rsp_err   <= 1'b0;
        end
      end
      if (r_state == S_WRITE) begin
        r_rsp_rdata <= 32'h0;
        r_rsp_err   <= 1'b0;
      end
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.mem_addr  = r_addr[31:2];
  assign bus.mem_re    = (r_state == S_RD_ISSUE);
  assign bus.mem_we    = (r_state == S_WRITE);
  assign bus.mem_wdata = (r_state != S_WRITE) ? 32'h0 :
                         (r_size == 2'b10)    ? r_wdata : r_merged;
endmodule

// File: tb/tb_mem_subword_unit.sv
// Bench for mem_subword_unit: directed table, back-to-back, reset abort, then random ops vs a lane-arithmetic model.
module tb_mem_subword_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_subword_unit_if bus_if ();
  mem_subword_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = 8'h0;
  logic [31:0] pl_dat = 32'h0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_dat;
    if (bus_if.mem_we) mem[bus_if.mem_addr[7:0]] <= bus_if.mem_wdata;
    if (bus_if.mem_re) bus_if.mem_rdata <= mem[bus_if.mem_addr[7:0]];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_re;
    int          exp_we;
    int          exp_rsp;
    logic [31:0] exp_wdata;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] init,
                              input logic [31:0] rd, input logic err, input int re, input int wec,
                              input int rsp, input logic [31:0] wd);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata; v.init = init;
    v.exp_rdata = rd; v.exp_err = err; v.exp_re = re; v.exp_we = wec; v.exp_rsp = rsp; v.exp_wdata = wd;
    return v;
  endfunction

  int re_c, we_c, rsp_c, re_n, we_n, viol;
  logic [31:0] wd, ma, rd;
  logic er;

  task automatic preload(input logic [7:0] idx, input logic [31:0] dat);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_dat = dat;
    @(posedge clk);
    #1 pl_en = 1'b0;
    ref_mem[idx] = dat;
    @(negedge clk);
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus_if.req_we = we; bus_if.req_size = size; bus_if.req_signed = sgn;
    bus_if.req_addr = addr; bus_if.req_wdata = wdata; bus_if.req_valid = 1'b1;
  endtask

  task automatic accept();
    int k = 0;
    while (!bus_if.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("req_ready_before_accept", {31'h0, bus_if.req_ready}, 32'h1);
    @(posedge clk);
    #1 bus_if.req_valid = 1'b0;
  endtask

  // Observes cycles 1.. after an acceptance edge until the response pulse (bounded).
  task automatic collect();
    re_c = 0; we_c = 0; rsp_c = 0; re_n = 0; we_n = 0; viol = 0;
    wd = 32'h0; ma = 32'h0; rd = 32'h0; er = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus_if.mem_re) begin
        re_n++;
        if (re_c == 0) begin re_c = k; ma = {2'b00, bus_if.mem_addr}; end
      end
      if (bus_if.mem_we) begin
        we_n++;
        if (we_c == 0) begin we_c = k; wd = bus_if.mem_wdata; ma = {2'b00, bus_if.mem_addr}; end
      end
      if (bus_if.mem_re && bus_if.mem_we) viol++;
      if (!bus_if.mem_we && bus_if.mem_wdata != 32'h0) viol++;
      if (bus_if.rsp_valid) begin
        rsp_c = k; rd = bus_if.rsp_rdata; er = bus_if.rsp_err;
        break;
      end
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    drive(v.we, v.size, v.sgn, v.addr, v.wdata);
    accept();
    collect();
    check({tag, " rsp_cycle"}, 32'(rsp_c), 32'(v.exp_rsp));
    check({tag, " rsp_rdata"}, rd, v.exp_rdata);
    check({tag, " rsp_err"}, {31'h0, er}, {31'h0, v.exp_err});
    check({tag, " mem_re_cycle"}, 32'(re_c), 32'(v.exp_re));
    check({tag, " mem_we_cycle"}, 32'(we_c), 32'(v.exp_we));
    check({tag, " mem_re_count"}, 32'(re_n), (v.exp_re != 0) ? 32'h1 : 32'h0);
    check({tag, " mem_we_count"}, 32'(we_n), (v.exp_we != 0) ? 32'h1 : 32'h0);
    check({tag, " strobe_rules"}, 32'(viol), 32'h0);
    if (v.exp_we != 0) check({tag, " mem_wdata"}, wd, v.exp_wdata);
    if (v.exp_re != 0 || v.exp_we != 0) check({tag, " mem_addr"}, ma, v.addr >> 2);
    @(negedge clk);
    check({tag, " rsp_one_cycle"}, {31'h0, bus_if.rsp_valid}, 32'h0);
    check({tag, " rsp_rdata_hold"}, bus_if.rsp_rdata, v.exp_rdata);
  endtask

  // Reference: lane arithmetic on a word array, updated as stores complete.
  function automatic vec_t model(input logic we, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata);
    vec_t v;
    int unsigned off, sh;
    logic [31:0] word, mask;
    int val;
    bit legal;
    v = mk(we, size, sgn, addr, wdata, 32'h0, 32'h0, 1'b0, 0, 0, 0, 32'h0);
    off  = addr % 4;
    sh   = 8 * off;
    word = ref_mem[(addr / 4) % 256];
    legal = (size == 2'd0) || (size == 2'd1 && addr % 2 == 0) || (size == 2'd2 && off == 0);
    if (!legal) begin
      v.exp_err = 1'b1; v.exp_rsp = 1;
    end else if (!we) begin
      v.exp_re = 1; v.exp_rsp = 3;
      if (size == 2'd2) v.exp_rdata = word;
      else begin
        mask = (size == 2'd0) ? 32'hFF : 32'hFFFF;
        val  = int'((word >> sh) & mask);
        if (sgn && val > int'(mask >> 1)) val = val - int'(mask) - 1;
        v.exp_rdata = 32'(val);
      end
    end else if (size == 2'd2) begin
      v.exp_we = 1; v.exp_rsp = 2; v.exp_wdata = wdata;
      ref_mem[(addr / 4) % 256] = wdata;
    end else begin
      mask = (size == 2'd0) ? 32'hFF : 32'hFFFF;
      v.exp_re = 1; v.exp_we = 3; v.exp_rsp = 4;
      v.exp_wdata = (word & ~(mask << sh)) | ((wdata & mask) << sh);
      ref_mem[(addr / 4) % 256] = v.exp_wdata;
    end
    return v;
  endfunction

  vec_t tbl [11];

  initial begin
    tbl[0]  = mk(1'b0, 2'b00, 1'b1, 32'h103, 32'h0,         32'h80FF_1234, 32'hFFFF_FF80, 1'b0, 1, 0, 3, 32'h0);
    tbl[1]  = mk(1'b0, 2'b01, 1'b0, 32'h102, 32'h0,         32'h80FF_1234, 32'h0000_80FF, 1'b0, 1, 0, 3, 32'h0);
    tbl[2]  = mk(1'b0, 2'b01, 1'b1, 32'h102, 32'h0,         32'h80FF_1234, 32'hFFFF_80FF, 1'b0, 1, 0, 3, 32'h0);
    tbl[3]  = mk(1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_00AB, 32'h1122_3344, 32'h0,         1'b0, 1, 3, 4, 32'h1122_AB44);
    tbl[4]  = mk(1'b1, 2'b10, 1'b0, 32'h010, 32'hDEAD_BEEF, 32'h0,         32'h0,         1'b0, 0, 1, 2, 32'hDEAD_BEEF);
    tbl[5]  = mk(1'b0, 2'b01, 1'b0, 32'h201, 32'h0,         32'h5555_5555, 32'h0,         1'b1, 0, 0, 1, 32'h0);
    tbl[6]  = mk(1'b0, 2'b11, 1'b0, 32'h000, 32'h0,         32'h5555_5555, 32'h0,         1'b1, 0, 0, 1, 32'h0);
    tbl[7]  = mk(1'b1, 2'b10, 1'b0, 32'h022, 32'h1234_5678, 32'h5555_5555, 32'h0,         1'b1, 0, 0, 1, 32'h0);
    tbl[8]  = mk(1'b1, 2'b01, 1'b0, 32'h106, 32'h1234_CAFE, 32'hAAAA_BBBB, 32'h0,         1'b0, 1, 3, 4, 32'hCAFE_BBBB);
    tbl[9]  = mk(1'b0, 2'b10, 1'b1, 32'h020, 32'h0,         32'h8000_0001, 32'h8000_0001, 1'b0, 1, 0, 3, 32'h0);
    tbl[10] = mk(1'b0, 2'b00, 1'b0, 32'h103, 32'h0,         32'h80FF_1234, 32'h0000_0080, 1'b0, 1, 0, 3, 32'h0);

    rst_n = 1'b0;
    bus_if.req_valid = 1'b0; bus_if.req_we = 1'b0; bus_if.req_size = 2'b00;
    bus_if.req_signed = 1'b0; bus_if.req_addr = 32'h0; bus_if.req_wdata = 32'h0;
    #1;
    check("reset req_ready", {31'h0, bus_if.req_ready}, 32'h1);
    check("reset rsp_valid", {31'h0, bus_if.rsp_valid}, 32'h0);
    check("reset rsp_rdata", bus_if.rsp_rdata, 32'h0);
    check("reset rsp_err",   {31'h0, bus_if.rsp_err}, 32'h0);
    check("reset mem_addr",  {2'b00, bus_if.mem_addr}, 32'h0);
    check("reset mem_re",    {31'h0, bus_if.mem_re}, 32'h0);
    check("reset mem_we",    {31'h0, bus_if.mem_we}, 32'h0);
    check("reset mem_wdata", bus_if.mem_wdata, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].exp_err == 1'b0) preload(8'(tbl[i].addr >> 2), tbl[i].init);
      run_vec($sformatf("vec%0d", i), tbl[i]);
    end

    // Word store followed by a load held on req_valid: the load is taken in cycle 3.
    begin
      int k_rdy = 0;
      int rsp_seen = 0;
      drive(1'b1, 2'b10, 1'b0, 32'h010, 32'hDEAD_BEEF);
      accept();
      drive(1'b0, 2'b00, 1'b1, 32'h010, 32'h0);
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (bus_if.rsp_valid && rsp_seen == 0) rsp_seen = k;
        if (bus_if.req_ready) begin k_rdy = k; break; end
      end
      check("b2b store rsp_cycle", 32'(rsp_seen), 32'd2);
      check("b2b second accept cycle", 32'(k_rdy), 32'd3);
      @(posedge clk);
      #1 bus_if.req_valid = 1'b0;
      collect();
      check("b2b load rsp_cycle", 32'(rsp_c), 32'd3);
      check("b2b load rsp_rdata", rd, 32'hFFFF_FFEF);
      @(negedge clk);
    end

    // Reset while a sub-word store sits in RD_WAIT: the write and response must never happen.
    begin
      int bad = 0;
      preload(8'h40, 32'h1122_3344);
      run_vec("pre_reset_load", mk(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h0, 32'h0000_0011, 1'b0, 1, 0, 3, 32'h0));
      drive(1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_00AB);
      accept();
      @(negedge clk);
      check("abort cycle1 mem_re", {31'h0, bus_if.mem_re}, 32'h1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort req_ready", {31'h0, bus_if.req_ready}, 32'h1);
      check("abort rsp_valid", {31'h0, bus_if.rsp_valid}, 32'h0);
      check("abort rsp_rdata", bus_if.rsp_rdata, 32'h0);
      check("abort rsp_err",   {31'h0, bus_if.rsp_err}, 32'h0);
      check("abort mem_addr",  {2'b00, bus_if.mem_addr}, 32'h0);
      check("abort mem_re",    {31'h0, bus_if.mem_re}, 32'h0);
      check("abort mem_we",    {31'h0, bus_if.mem_we}, 32'h0);
      check("abort mem_wdata", bus_if.mem_wdata, 32'h0);
      repeat (2) begin
        @(negedge clk);
        if (bus_if.mem_we || bus_if.mem_re || bus_if.rsp_valid) bad++;
      end
      rst_n = 1'b1;
      repeat (5) begin
        @(negedge clk);
        if (bus_if.mem_we || bus_if.mem_re || bus_if.rsp_valid || !bus_if.req_ready) bad++;
      end
      check("abort quiet after reset", 32'(bad), 32'h0);
      check("abort memory untouched", mem[8'h40], 32'h1122_3344);
      run_vec("post_reset_load", mk(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'h0, 32'h0000_0033, 1'b0, 1, 0, 3, 32'h0));
    end

    for (int i = 0; i < 256; i++) preload(8'(i), $urandom);
    for (int n = 0; n < 150; n++) begin
      vec_t v;
      logic we;
      logic [1:0] size;
      logic sgn;
      logic [31:0] addr, wdata;
      we    = 1'($urandom_range(0, 1));
      size  = 2'($urandom_range(0, 3));
      sgn   = 1'($urandom_range(0, 1));
      addr  = 32'($urandom_range(0, 1023));
      wdata = $urandom;
      v = model(we, size, sgn, addr, wdata);
      run_vec($sformatf("rand%0d", n), v);
    end
    for (int i = 0; i < 256; i++) check($sformatf("final mem[%0d]", i), mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
